param_fifo: RTL and testbench

Parametrised synchronous FIFO. Next generation of the fixed-width shift-register fifo used behind the CCI-P MMIO path in the AFU.
- Adds configurable width and depth, valid/ready handshakes on both sides, and first-word-fall-through output.
- Adds occupancy count, almost-full threshold, synchronous flush, and sticky overflow/underflow flags for MMIO status readback.
- Sits between the Rx c0 MMIO write decode (producer) and the Tx c2 read-response path (consumer).

---
 rtl/param_fifo_pkg.sv | 21 ++
 rtl/param_fifo_mem.sv | 38 +++
 rtl/param_fifo.sv | 123 ++++++++++++
 tb/tb_param_fifo.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/param_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : param_fifo_pkg
//  Description : Sizing helpers shared by the parametrised FIFO and its
//                storage array.
//  Revision    : 1.0 - initial release
// ============================================================================
package param_fifo_pkg;

    // Pointer width: enough bits to index DEPTH entries (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width: must be able to represent the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/param_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : param_fifo_mem
//  Description : DEPTH x WIDTH register array, one synchronous write port and
//                one asynchronous read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_fifo_mem
    import param_fifo_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: store the pushed word at the write address.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: combinational so the head word falls through immediately.
    always_comb begin
        o_rdata = r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/param_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : param_fifo
//  Description : Parametrised first-word-fall-through FIFO with valid/ready
//                on both sides, occupancy count, almost-full threshold,
//                synchronous flush and sticky overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    localparam logic [PTR_W-1:0] c_ptr_last  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_full  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_afull = CNT_W'(AFULL_THRESH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic             w_mem_we;

    // Handshake status depends on occupancy only, never on the far side.
    always_comb begin
        w_in_ready  = (r_count != c_cnt_full);
        w_out_valid = (r_count != '0);
        w_push      = in_valid  & w_in_ready;
        w_pop       = out_valid & out_ready;
        // Data offered during a flush is dropped, so it must not be written.
        w_mem_we    = w_push & ~flush;
    end

    // Pointer advance with explicit wrap; DEPTH need not be a power of two.
    always_comb begin
        w_wr_ptr_nxt = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
        w_rd_ptr_nxt = (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
    end

    // Pointer, occupancy and sticky-flag state; flush overrides push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow  <= r_overflow  | (in_valid  & ~w_in_ready);
            r_underflow <= r_underflow | (out_ready & ~w_out_valid);
        end
    end

    param_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (out_data)
    );

    // Drive the status outputs from registered state.
    always_comb begin
        in_ready    = w_in_ready;
        out_valid   = w_out_valid;
        count       = r_count;
        almost_full = (r_count >= c_cnt_afull);
        overflow    = r_overflow;
        underflow   = r_underflow;
    end

endmodule
`default_nettype wire

// File: tb/tb_param_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_fifo
//  Description : Scoreboard bench for param_fifo, one DEPTH=8 build and one
//                DEPTH=5 build driven with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_fifo;

    localparam int W = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=8, AFULL_THRESH=6 instance
    logic          a_flush = 1'b0, a_iv = 1'b0, a_or = 1'b0;
    logic [W-1:0]  a_id = '0;
    logic          a_ir, a_ov, a_af, a_ovf, a_udf;
    logic [W-1:0]  a_od;
    logic [3:0]    a_cnt;

    // DEPTH=5, AFULL_THRESH=4 instance
    logic          b_flush = 1'b0, b_iv = 1'b0, b_or = 1'b0;
    logic [W-1:0]  b_id = '0;
    logic          b_ir, b_ov, b_af, b_ovf, b_udf;
    logic [W-1:0]  b_od;
    logic [2:0]    b_cnt;

    param_fifo #(.WIDTH(W), .DEPTH(8), .AFULL_THRESH(6)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .count(a_cnt), .almost_full(a_af), .overflow(a_ovf), .underflow(a_udf)
    );

    param_fifo #(.WIDTH(W), .DEPTH(5), .AFULL_THRESH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .count(b_cnt), .almost_full(b_af), .overflow(b_ovf), .underflow(b_udf)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state for each instance
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int           ma_cnt = 0, mb_cnt = 0;
    logic         ma_ovf = 1'b0, ma_udf = 1'b0, mb_ovf = 1'b0, mb_udf = 1'b0;

    // Monitor A: check outputs against the model, then step the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            ma_cnt = 0; ma_ovf = 1'b0; ma_udf = 1'b0;
        end else begin
            chk("a_count",       W'(a_cnt), W'(ma_cnt));
            chk("a_in_ready",    W'(a_ir),  W'(ma_cnt != 8));
            chk("a_out_valid",   W'(a_ov),  W'(ma_cnt != 0));
            chk("a_almost_full", W'(a_af),  W'(ma_cnt >= 6));
            chk("a_overflow",    W'(a_ovf), W'(ma_ovf));
            chk("a_underflow",   W'(a_udf), W'(ma_udf));
            if (a_flush) begin
                qa.delete();
                ma_cnt = 0; ma_ovf = 1'b0; ma_udf = 1'b0;
            end else begin
                automatic bit push = a_iv && (ma_cnt != 8);
                automatic bit pop  = a_or && (ma_cnt != 0);
                if (a_iv && ma_cnt == 8) ma_ovf = 1'b1;
                if (a_or && ma_cnt == 0) ma_udf = 1'b1;
                if (pop) chk("a_out_data", a_od, qa.pop_front());
                if (push) qa.push_back(a_id);
                ma_cnt = ma_cnt + int'(push) - int'(pop);
            end
        end
    end

    // Monitor B: same scheme for the non-power-of-two build.
    always @(negedge clk) begin
        if (!rst_n) begin
            qb.delete();
            mb_cnt = 0; mb_ovf = 1'b0; mb_udf = 1'b0;
        end else begin
            chk("b_count",       W'(b_cnt), W'(mb_cnt));
            chk("b_in_ready",    W'(b_ir),  W'(mb_cnt != 5));
            chk("b_out_valid",   W'(b_ov),  W'(mb_cnt != 0));
            chk("b_almost_full", W'(b_af),  W'(mb_cnt >= 4));
            chk("b_overflow",    W'(b_ovf), W'(mb_ovf));
            chk("b_underflow",   W'(b_udf), W'(mb_udf));
            if (b_flush) begin
                qb.delete();
                mb_cnt = 0; mb_ovf = 1'b0; mb_udf = 1'b0;
            end else begin
                automatic bit push = b_iv && (mb_cnt != 5);
                automatic bit pop  = b_or && (mb_cnt != 0);
                if (b_iv && mb_cnt == 5) mb_ovf = 1'b1;
                if (b_or && mb_cnt == 0) mb_udf = 1'b1;
                if (pop) chk("b_out_data", b_od, qb.pop_front());
                if (push) qb.push_back(b_id);
                mb_cnt = mb_cnt + int'(push) - int'(pop);
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #22 rst_n = 1'b1;
        cyc();
        chk("reset_count",     W'(a_cnt), W'(0));
        chk("reset_in_ready",  W'(a_ir),  W'(1));
        chk("reset_out_valid", W'(a_ov),  W'(0));

        // Fill with 0x11..0x88 while the consumer stalls.
        for (int i = 0; i < 8; i++) begin
            a_iv = 1'b1; a_id = W'((i + 1) * 'h11);
            cyc();
        end
        a_iv = 1'b0;
        chk("full_count",       W'(a_cnt), W'(8));
        chk("full_in_ready",    W'(a_ir),  W'(0));
        chk("full_almost_full", W'(a_af),  W'(1));
        chk("full_head",        a_od,      W'('h11));
        cyc();
        chk("stall_head_stable", a_od, W'('h11));

        // Drain in order.
        a_or = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        a_or = 1'b0;
        chk("drain_count",     W'(a_cnt), W'(0));
        chk("drain_out_valid", W'(a_ov),  W'(0));

        // Full with simultaneous push and pop: only the pop happens.
        for (int i = 0; i < 8; i++) begin
            a_iv = 1'b1; a_id = W'('h100 + i);
            cyc();
        end
        a_id = W'('hBAD); a_or = 1'b1;
        cyc();
        a_iv = 1'b0; a_or = 1'b0;
        chk("full_pp_count",    W'(a_cnt), W'(7));
        chk("full_pp_overflow", W'(a_ovf), W'(1));

        // Drain the remaining 7, then one extra pop attempt at empty.
        a_or = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        a_or = 1'b0;
        chk("empty_underflow", W'(a_udf), W'(1));
        chk("empty_count",     W'(a_cnt), W'(0));

        // First-word-fall-through latency: visible one cycle after the push.
        a_iv = 1'b1; a_id = W'('hDEADBEEF);
        chk("fwft_not_same_cycle", W'(a_ov), W'(0));
        cyc();
        a_iv = 1'b0;
        chk("fwft_valid", W'(a_ov), W'(1));
        chk("fwft_data",  a_od,     W'('hDEADBEEF));
        a_or = 1'b1;
        cyc();
        a_or = 1'b0;

        // Flush at count 5 with overflow still set, alongside push and pop.
        for (int i = 0; i < 5; i++) begin
            a_iv = 1'b1; a_id = W'('h51 + i);
            cyc();
        end
        chk("preflush_count",    W'(a_cnt), W'(5));
        chk("preflush_overflow", W'(a_ovf), W'(1));
        a_flush = 1'b1; a_id = W'('hFF); a_or = 1'b1;
        cyc();
        a_flush = 1'b0; a_iv = 1'b0; a_or = 1'b0;
        chk("flush_count",     W'(a_cnt), W'(0));
        chk("flush_overflow",  W'(a_ovf), W'(0));
        chk("flush_underflow", W'(a_udf), W'(0));
        chk("flush_out_valid", W'(a_ov),  W'(0));
        a_iv = 1'b1; a_id = W'('h77);
        cyc();
        a_iv = 1'b0;
        chk("flush_push_entry0", u_a.u_mem.r_mem[0], W'('h77));
        chk("flush_push_head",   a_od,               W'('h77));
        a_or = 1'b1;
        cyc();
        a_or = 1'b0;

        // DEPTH=5: preload 3, then 20 cycles of simultaneous push and pop.
        for (int i = 0; i < 3; i++) begin
            b_iv = 1'b1; b_id = W'(i + 1);
            cyc();
        end
        b_or = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b_id = W'(4 + i);
            cyc();
            chk("b_steady_count", W'(b_cnt), W'(3));
        end
        b_iv = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        b_or = 1'b0;
        chk("b_drain_count", W'(b_cnt), W'(0));

        // Asynchronous reset mid-cycle at count 4.
        for (int i = 0; i < 4; i++) begin
            a_iv = 1'b1; a_id = W'('h41 + i);
            cyc();
        end
        a_iv = 1'b0;
        chk("prereset_count", W'(a_cnt), W'(4));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count",     W'(a_cnt), W'(0));
        chk("async_rst_in_ready",  W'(a_ir),  W'(1));
        chk("async_rst_out_valid", W'(a_ov),  W'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        a_iv = 1'b1; a_id = W'('hA5);
        cyc();
        a_iv = 1'b0;
        chk("rst_push_entry0", u_a.u_mem.r_mem[0], W'('hA5));
        chk("rst_push_head",   a_od,               W'('hA5));
        a_or = 1'b1;
        cyc();
        a_or = 1'b0;
        chk("rst_pop_count", W'(a_cnt), W'(0));
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
